// File: rtl/sim_sequencer.sv
// Simulation sweep sequencer.
// Waits spd_l cycles, then walks every cell of a res_l x res_l grid in raster
// order through a valid/ready handshake, pulses done and counts the sweep.
// Resolution and speed are latched only when entering WAIT, so the engine
// always sees a stable grid for the whole sweep.
module sim_sequencer #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_active_i,
  input  logic [8:0]        resolution_i,
  input  logic [11:0]       speed_i,
  input  logic              cell_ready_i,
  output logic              cell_valid_o,
  output logic [8:0]        cell_x_o,
  output logic [8:0]        cell_y_o,
  output logic              sweep_start_o,
  output logic              sweep_done_o,
  output logic              busy_o,
  output logic [STEP_W-1:0] step_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [8:0]        res_q;
  logic [11:0]       spd_q;
  logic [11:0]       timer_q;
  logic [8:0]        x_q, y_q;
  logic              start_q;
  logic [STEP_W-1:0] step_q;

  // Values to latch on entry to WAIT; zero is clamped to one.
  logic [8:0]  res_d;
  logic [11:0] spd_d;
  logic        xfer, last_x, last_y, wait_end;

  // Input clamping and sweep position decode.
  always_comb begin
    res_d    = (resolution_i == 9'd0) ? 9'd1 : resolution_i;
    spd_d    = (speed_i == 12'd0) ? 12'd1 : speed_i;
    xfer     = (state_q == S_SWEEP) && cell_ready_i;
    last_x   = (x_q == res_q - 9'd1);
    last_y   = (y_q == res_q - 9'd1);
    wait_end = (timer_q == spd_q - 12'd1);
  end

  // Sequencer FSM with its timer, coordinates and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= 9'd1;
      spd_q   <= 12'd1;
      timer_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      start_q <= 1'b0;
      step_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (game_active_i) begin
            state_q <= S_WAIT;
            res_q   <= res_d;
            spd_q   <= spd_d;
            timer_q <= '0;
          end
        end
        S_WAIT: begin
          if (!game_active_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else if (wait_end) begin
            state_q <= S_SWEEP;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 12'd1;
          end
        end
        S_SWEEP: begin
          // The start pulse covers only the first SWEEP cycle, stalled or not.
          start_q <= 1'b0;
          if (xfer) begin
            if (!last_x) begin
              x_q <= x_q + 9'd1;
            end else begin
              x_q <= '0;
              if (last_y) begin
                // Count is already updated while DONE is presented.
                y_q     <= '0;
                state_q <= S_DONE;
                step_q  <= step_q + 1'b1;
              end else begin
                y_q <= y_q + 9'd1;
              end
            end
          end
        end
        S_DONE: begin
          if (game_active_i) begin
            state_q <= S_WAIT;
            res_q   <= res_d;
            spd_q   <= spd_d;
            timer_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers, so reset clears them at once.
  always_comb begin
    cell_valid_o  = (state_q == S_SWEEP);
    cell_x_o      = cell_valid_o ? x_q : 9'd0;
    cell_y_o      = cell_valid_o ? y_q : 9'd0;
    sweep_start_o = start_q && (state_q == S_SWEEP);
    sweep_done_o  = (state_q == S_DONE);
    busy_o        = (state_q != S_IDLE);
    step_count_o  = step_q;
  end

endmodule

// File: doc/sim_sequencer.md
SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 The block SHALL have parameter STEP_W, default 16, giving the width of step_count_o.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port game_active_i, input, 1: the simulation runs while high.
REQ-005 The block SHALL have port resolution_i, input, 9: grid edge length in cells.
REQ-006 The block SHALL have port speed_i, input, 12: clock cycles between sweeps.
REQ-007 The block SHALL have port cell_ready_i, input, 1: the update engine accepts the presented cell.
REQ-008 The block SHALL have port cell_valid_o, output, 1: cell_x_o/cell_y_o hold a valid cell address.
REQ-009 The block SHALL have ports cell_x_o and cell_y_o, output, 9 each: the current cell column and row.
REQ-010 The block SHALL have port sweep_start_o, output, 1: a one-cycle pulse in the first SWEEP cycle.
REQ-011 The block SHALL have port sweep_done_o, output, 1: a one-cycle pulse when a sweep completes.
REQ-012 The block SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-013 The block SHALL have port step_count_o, output, STEP_W: the number of completed sweeps.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, SWEEP, DONE.
REQ-015 In IDLE, game_active_i high SHALL cause a transition to WAIT on the next edge, latching res_l = max(resolution_i,1) and spd_l = max(speed_i,1).
REQ-016 In IDLE and WAIT, the inputs SHALL be sampled only at the IDLE->WAIT and DONE->WAIT transitions; resolution_i/speed_i changes at other times SHALL be ignored.
REQ-017 Entering WAIT SHALL clear the timer; the timer increments once per WAIT cycle.
REQ-018 WAIT SHALL last exactly spd_l cycles, then transition to SWEEP with x=0, y=0.
REQ-019 In WAIT, game_active_i low SHALL cause a transition to IDLE on the next edge, with the timer cleared and no sweep.
REQ-020 In SWEEP, cell_valid_o SHALL be 1, and sweep_start_o SHALL be 1 only in the first SWEEP cycle.
REQ-021 Handshake: a cell transfers on a cycle with cell_valid_o and cell_ready_i both high; without a transfer, x/y SHALL hold stable.
REQ-022 On transfer: if x < res_l-1, x increments; otherwise x becomes 0 and y increments (raster order, x fastest).
REQ-023 A transfer at x=res_l-1 and y=res_l-1 SHALL end the sweep, and the next state SHALL be DONE.
REQ-024 game_active_i dropping in SWEEP SHALL NOT abort the sweep; the sweep completes normally.
REQ-025 DONE SHALL last one cycle, with sweep_done_o=1 and step_count_o incremented by 1 (modulo 2^STEP_W, wrapping).
REQ-026 From DONE, the next state SHALL be WAIT (inputs re-latched) if game_active_i is high, otherwise IDLE.
REQ-027 Outside SWEEP, cell_valid_o SHALL be 0, and cell_x_o/cell_y_o SHALL be 0.
REQ-028 Each sweep SHALL issue exactly res_l*res_l transfers.
REQ-029 step_count_o SHALL NOT clear when game_active_i falls.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state=IDLE, timer=0, x=y=0 and step_count_o=0.
REQ-031 rst_n low SHALL immediately force cell_valid_o, sweep_start_o, sweep_done_o and busy_o to 0.
REQ-032 Reset release SHALL take effect at the first clk edge after rst_n rises; no other reset source exists.

Verification
REQ-033 Reset: assert rst_n low mid-SWEEP between clock edges -> all outputs 0 before the next edge; step_count_o=0.
REQ-034 Nominal: resolution_i=2, speed_i=3, ready=1, game_active_i raised at cycle 0 -> WAIT cycles 1-3; coordinates (0,0),(1,0),(0,1),(1,1) in cycles 4-7 with sweep_start_o in cycle 4; sweep_done_o in cycle 8; step_count_o=1; WAIT again from cycle 9.
REQ-035 Backpressure: resolution_i=3, cell_ready_i toggling 1,0,0,1,... -> x/y stable while ready=0; exactly 9 transfers in raster order; one done pulse.
REQ-036 Stop mid-sweep: drop game_active_i after 2 transfers of a 4-cell sweep -> remaining 2 transfers occur, then done pulse, step_count_o increments, state IDLE, busy_o=0.
REQ-037 Degenerate: resolution_i=0, speed_i=0 -> WAIT lasts 1 cycle; single cell (0,0); done pulse; sweep repeats every 3 cycles while active.
REQ-038 Wrap and relatch: preload step_count_o to 2^STEP_W-1, complete a sweep -> step_count_o=0; change resolution_i mid-sweep -> the new value is used only from the next WAIT.
